// File: rtl/sn74ls31_syncdly.sv
// Clocked, tap-selectable delay stage with a non-retriggerable one-shot pulse
// on each delayed rising edge; sits behind the sn74ls31 delay elements.
module sn74ls31_syncdly #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned TAPW  = 4,
   parameter int unsigned PW    = 4,
   parameter int unsigned HO    = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            d,
   input  logic [TAPW-1:0] tap,
   input  logic            load,
   output logic            y,
   output logic            yn,
   output logic            pulse,
   output logic            busy
);

   localparam int unsigned CNT_MAX = (PW > HO) ? PW : HO;
   localparam int unsigned CNTW    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [TAPW-1:0] TAP_MAX = TAPW'(DEPTH - 1);
   localparam logic [CNTW-1:0] CNT_PW  = CNTW'(PW - 1);
   localparam logic [CNTW-1:0] CNT_HO  = CNTW'((HO > 0) ? HO - 1 : 0);
   localparam bit              HAS_HO  = (HO > 0);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PULSE   = 2'd1,
      S_HOLDOFF = 2'd2
   } state_t;

   logic [DEPTH-1:0] sr_q;
   logic [TAPW-1:0]  tap_q;
   logic [TAPW-1:0]  tap_clamped;
   logic             dly_prev;
   logic             sup;
   logic             rise;
   state_t           state_q;
   state_t           state_d;
   logic [CNTW-1:0]  cnt_q;
   logic [CNTW-1:0]  cnt_d;

   // Delay line: one stage per clock, d enters at stage 0
   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q <= '0;
      end else begin
         sr_q <= {sr_q[DEPTH-2:0], d};
      end
   end

   // Out-of-range tap requests select the last stage
   always_comb begin
      tap_clamped = tap;
      if (tap > TAP_MAX) begin
         tap_clamped = TAP_MAX;
      end
   end

   // Tap register, previous-level history and post-load edge suppression
   always_ff @(posedge clk) begin
      if (rst) begin
         tap_q    <= '0;
         dly_prev <= 1'b0;
         sup      <= 1'b0;
      end else begin
         if (load) begin
            tap_q <= tap_clamped;
         end
         dly_prev <= y;
         sup      <= load;
      end
   end

   assign y    = sr_q[tap_q];
   assign yn   = ~y;
   // sup masks the apparent edge created when the tap moves onto a different level
   assign rise = y & ~dly_prev & ~sup;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state; edges outside IDLE are dropped, never queued
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (rise) begin
               state_d = S_PULSE;
               cnt_d   = CNT_PW;
            end
         end
         S_PULSE: begin
            if (cnt_q == '0) begin
               if (HAS_HO) begin
                  state_d = S_HOLDOFF;
                  cnt_d   = CNT_HO;
               end else begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         S_HOLDOFF: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM outputs decoded straight from the state register
   always_comb begin
      pulse = 1'b0;
      busy  = 1'b0;
      case (state_q)
         S_PULSE: begin
            pulse = 1'b1;
            busy  = 1'b1;
         end
         S_HOLDOFF: begin
            busy = 1'b1;
         end
         default: begin
            pulse = 1'b0;
            busy  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_sn74ls31_syncdly.sv
// Directed bench for sn74ls31_syncdly: default instance plus a DEPTH=12, HO=0
// instance for tap clamping and the no-hold-off pulse path.
module tb_sn74ls31_syncdly;

   logic       clk = 1'b0;
   logic       rst;
   logic       d;
   logic [3:0] tap;
   logic       load;
   logic       y;
   logic       yn;
   logic       pulse;
   logic       busy;

   logic       d2;
   logic [3:0] tap2;
   logic       load2;
   logic       y2;
   logic       yn2;
   logic       pulse2;
   logic       busy2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sn74ls31_syncdly #(.DEPTH(16), .TAPW(4), .PW(4), .HO(2)) dut (
      .clk(clk), .rst(rst), .d(d), .tap(tap), .load(load),
      .y(y), .yn(yn), .pulse(pulse), .busy(busy)
   );

   sn74ls31_syncdly #(.DEPTH(12), .TAPW(4), .PW(2), .HO(0)) dut2 (
      .clk(clk), .rst(rst), .d(d2), .tap(tap2), .load(load2),
      .y(y2), .yn(yn2), .pulse(pulse2), .busy(busy2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic flush(input int n);
      d    = 1'b0;
      load = 1'b0;
      repeat (n) step();
   endtask

   task automatic load_tap(input logic [3:0] t);
      tap  = t;
      load = 1'b1;
      step();
      load = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; d = 1'b1; tap = 4'd5; load = 1'b1;
      d2 = 1'b1; tap2 = 4'd3; load2 = 1'b1;
      repeat (3) step();
      n_cmp++; if (y !== 1'b0) begin n_bad++; $display("FAIL reset_y: got %b want 0", y); end
      n_cmp++; if (yn !== 1'b1) begin n_bad++; $display("FAIL reset_yn: got %b want 1", yn); end
      n_cmp++; if (pulse !== 1'b0) begin n_bad++; $display("FAIL reset_pulse: got %b want 0", pulse); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (dut.tap_q !== 4'd0) begin n_bad++; $display("FAIL reset_tap_q: got %0d want 0", dut.tap_q); end
      n_cmp++; if (dut2.tap_q !== 4'd0) begin n_bad++; $display("FAIL reset_tap_q2: got %0d want 0", dut2.tap_q); end
      rst = 1'b0; d = 1'b0; load = 1'b0; tap = 4'd0;
      d2 = 1'b0; load2 = 1'b0;
      step();
      n_cmp++; if (y !== 1'b0) begin n_bad++; $display("FAIL reset_sr_cleared: got %b want 0", y); end
   endtask

   task automatic test_latency();
      logic exp_y;
      flush(2);
      load_tap(4'd3);
      d = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         exp_y = (k >= 4);
         n_cmp++; if (y !== exp_y) begin n_bad++; $display("FAIL latency3_y k=%0d: got %b want %b", k, y, exp_y); end
         n_cmp++; if (yn !== ~exp_y) begin n_bad++; $display("FAIL latency3_yn k=%0d: got %b want %b", k, yn, ~exp_y); end
      end
      flush(20);
      load_tap(4'd15);
      d = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         step();
         exp_y = (k >= 16);
         n_cmp++; if (y !== exp_y) begin n_bad++; $display("FAIL latency15_y k=%0d: got %b want %b", k, y, exp_y); end
      end
      flush(24);
   endtask

   task automatic test_clamp_no_holdoff();
      logic exp_y;
      logic exp_p;
      tap2 = 4'd14; load2 = 1'b1;
      step();
      load2 = 1'b0;
      n_cmp++; if (dut2.tap_q !== 4'd11) begin n_bad++; $display("FAIL clamp_tap_q: got %0d want 11", dut2.tap_q); end
      step();
      d2 = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         step();
         exp_y = (k >= 12);
         exp_p = (k == 13 || k == 14);
         n_cmp++; if (y2 !== exp_y) begin n_bad++; $display("FAIL clamp_y k=%0d: got %b want %b", k, y2, exp_y); end
         n_cmp++; if (yn2 !== ~exp_y) begin n_bad++; $display("FAIL clamp_yn k=%0d: got %b want %b", k, yn2, ~exp_y); end
         n_cmp++; if (pulse2 !== exp_p) begin n_bad++; $display("FAIL ho0_pulse k=%0d: got %b want %b", k, pulse2, exp_p); end
         n_cmp++; if (busy2 !== exp_p) begin n_bad++; $display("FAIL ho0_busy k=%0d: got %b want %b", k, busy2, exp_p); end
      end
      d2 = 1'b0;
      repeat (14) step();
   endtask

   task automatic test_one_shot();
      logic exp_p;
      logic exp_b;
      load_tap(4'd0);
      flush(2);
      d = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         step();
         exp_p = (k >= 2 && k <= 5);
         exp_b = (k >= 2 && k <= 7);
         n_cmp++; if (pulse !== exp_p) begin n_bad++; $display("FAIL oneshot_pulse k=%0d: got %b want %b", k, pulse, exp_p); end
         n_cmp++; if (busy !== exp_b) begin n_bad++; $display("FAIL oneshot_busy k=%0d: got %b want %b", k, busy, exp_b); end
      end
      flush(4);
   endtask

   task automatic test_back_to_back();
      // level seen on y after edge k is ypat[k-1]; rises at k=1,4,8,13,15
      logic [0:21] ypat;
      logic        exp_p;
      logic        exp_b;
      ypat = 22'b1101100110001011000000;
      for (int k = 1; k <= 22; k++) begin
         d = ypat[k-1];
         step();
         exp_p = (k >= 2 && k <= 5) || (k >= 9 && k <= 12) || (k >= 16 && k <= 19);
         exp_b = (k >= 2 && k <= 7) || (k >= 9 && k <= 14) || (k >= 16 && k <= 21);
         n_cmp++; if (y !== ypat[k-1]) begin n_bad++; $display("FAIL b2b_y k=%0d: got %b want %b", k, y, ypat[k-1]); end
         n_cmp++; if (pulse !== exp_p) begin n_bad++; $display("FAIL b2b_pulse k=%0d: got %b want %b", k, pulse, exp_p); end
         n_cmp++; if (busy !== exp_b) begin n_bad++; $display("FAIL b2b_busy k=%0d: got %b want %b", k, busy, exp_b); end
      end
      flush(4);
   endtask

   task automatic test_tap_change();
      logic exp_y;
      load_tap(4'd8);
      flush(12);
      for (int j = 0; j < 4; j++) begin
         d = 1'b1;
         step();
         n_cmp++; if (y !== 1'b0) begin n_bad++; $display("FAIL tapchg_pre_y j=%0d: got %b want 0", j, y); end
      end
      d = 1'b0; tap = 4'd2; load = 1'b1;
      step();
      load = 1'b0;
      n_cmp++; if (y !== 1'b1) begin n_bad++; $display("FAIL tapchg_y: got %b want 1", y); end
      n_cmp++; if (pulse !== 1'b0) begin n_bad++; $display("FAIL tapchg_pulse0: got %b want 0", pulse); end
      for (int k = 6; k <= 10; k++) begin
         step();
         exp_y = (k == 6);
         n_cmp++; if (y !== exp_y) begin n_bad++; $display("FAIL tapchg_y k=%0d: got %b want %b", k, y, exp_y); end
         n_cmp++; if (pulse !== 1'b0) begin n_bad++; $display("FAIL tapchg_pulse k=%0d: got %b want 0", k, pulse); end
         n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tapchg_busy k=%0d: got %b want 0", k, busy); end
      end
      flush(16);
   endtask

   task automatic test_sup_and_load_rise();
      load_tap(4'd0);
      flush(2);
      // reloading the same tap still masks the edge that arrives with it
      d = 1'b1; tap = 4'd0; load = 1'b1;
      step();
      load = 1'b0;
      n_cmp++; if (y !== 1'b1) begin n_bad++; $display("FAIL sup_same_y: got %b want 1", y); end
      for (int k = 2; k <= 6; k++) begin
         step();
         n_cmp++; if (pulse !== 1'b0) begin n_bad++; $display("FAIL sup_same_pulse k=%0d: got %b want 0", k, pulse); end
      end
      flush(3);
      // load arriving with a live rise: the rise on the old tap still fires
      d = 1'b1;
      step();
      tap = 4'd4; load = 1'b1;
      step();
      load = 1'b0;
      n_cmp++; if (pulse !== 1'b1) begin n_bad++; $display("FAIL load_rise_pulse: got %b want 1", pulse); end
      n_cmp++; if (dut.tap_q !== 4'd4) begin n_bad++; $display("FAIL load_rise_tap_q: got %0d want 4", dut.tap_q); end
      flush(12);
   endtask

   task automatic test_reset_mid_pulse();
      load_tap(4'd0);
      flush(3);
      d = 1'b1;
      step();
      step();
      n_cmp++; if (pulse !== 1'b1) begin n_bad++; $display("FAIL midrst_pulse1: got %b want 1", pulse); end
      step();
      n_cmp++; if (pulse !== 1'b1) begin n_bad++; $display("FAIL midrst_pulse2: got %b want 1", pulse); end
      rst = 1'b1; d = 1'b0;
      step();
      n_cmp++; if (pulse !== 1'b0) begin n_bad++; $display("FAIL midrst_pulse_drop: got %b want 0", pulse); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy_drop: got %b want 0", busy); end
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         n_cmp++; if (pulse !== 1'b0) begin n_bad++; $display("FAIL midrst_after_pulse k=%0d: got %b want 0", k, pulse); end
         n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_after_busy k=%0d: got %b want 0", k, busy); end
      end
   endtask

   initial begin
      rst = 1'b1; d = 1'b0; tap = 4'd0; load = 1'b0;
      d2 = 1'b0; tap2 = 4'd0; load2 = 1'b0;
      test_reset();
      test_latency();
      test_clamp_no_holdoff();
      test_one_shot();
      test_back_to_back();
      test_tap_change();
      test_sup_and_load_rise();
      test_reset_mid_pulse();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
